// File: rtl/div_mult_unit.sv
// div_mult_unit: iterative signed 32x32 multiplier / divider.
//
// MULT (ctrl 01) yields the 64-bit signed product as {Hi, Lo}.
// DIV (ctrl 10) yields Lo = quotient (truncated toward zero) and
// Hi = remainder (sign of the dividend).
// Both operations run on operand magnitudes for 32 cycles, one bit per cycle.
// The signs are applied to the final iteration's value as it is written into Hi/Lo.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-low reset
//   start         one-cycle operation request, honoured only in IDLE
//   div_mult_ctrl 01 = MULT, 10 = DIV, others = no operation
//   A, B          signed operands
//   Hi, Lo        result register, written only when entering DONE
//   busy          high while iterating
//   done          one-cycle pulse, result valid on Hi/Lo
//   div_zero      one-cycle pulse after a DIV request with B == 0
module div_mult_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  div_mult_ctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {StIdle, StMultRun, StDivRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        a_neg_q, a_neg_d;
  logic [31:0] b_q, b_d;
  // MULT: {partial high, shifting multiplier}; DIV: {remainder, shifting dividend/quotient}
  logic [63:0] work_q, work_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

  logic [31:0] a_mag_in, b_mag;
  logic [32:0] mult_add;
  logic [63:0] mult_next, mult_res;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;
  logic [31:0] div_quo, div_rem, div_lo, div_hi;
  logic        res_neg;

  // Magnitudes; 0x80000000 maps to itself, which is correct as unsigned 2^31.
  assign a_mag_in = A[31] ? -A : A;
  assign b_mag    = b_q[31] ? -b_q : b_q;
  assign res_neg  = a_neg_q ^ b_q[31];

  // Shift-add: conditionally add the multiplicand to the high half, shift right.
  assign mult_add  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, b_mag} : 33'd0);
  assign mult_next = {mult_add, work_q[31:1]};
  assign mult_res  = res_neg ? -mult_next : mult_next;

  // Restoring division; remainder < divisor <= 2^31 so the shifted value fits 33 bits
  // and bit 32 of the difference is the borrow.
  assign div_shift = {work_q[63:32], work_q[31]};
  assign div_diff  = div_shift - {1'b0, b_mag};
  assign div_next  = div_diff[32] ? {div_shift[31:0], work_q[30:0], 1'b0}
                                  : {div_diff[31:0], work_q[30:0], 1'b1};
  assign div_quo   = div_next[31:0];
  assign div_rem   = div_next[63:32];
  assign div_lo    = res_neg ? -div_quo : div_quo;
  assign div_hi    = a_neg_q ? -div_rem : div_rem;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_neg_d    = a_neg_q;
    b_d        = b_q;
    work_d     = work_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (div_mult_ctrl == 2'b01 || (div_mult_ctrl == 2'b10 && B != 32'd0))) begin
          a_neg_d = A[31];
          b_d     = B;
          work_d  = {32'd0, a_mag_in};
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
          state_d = (div_mult_ctrl == 2'b01) ? StMultRun : StDivRun;
        end else if (start && div_mult_ctrl == 2'b10) begin
          div_zero_d = 1'b1;
        end
      end
      StMultRun, StDivRun: begin
        work_d = (state_q == StMultRun) ? mult_next : div_next;
        cnt_d  = cnt_q + 6'd1;
        busy_d = 1'b1;
        if (cnt_q == 6'd31) begin
          busy_d  = 1'b0;
          state_d = StDone;
          if (state_q == StMultRun) begin
            {hi_d, lo_d} = mult_res;
          end else begin
            hi_d = div_hi;
            lo_d = div_lo;
          end
        end
      end
      StDone: begin
        // done is registered, so it is seen in the cycle after DONE.
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      a_neg_q    <= 1'b0;
      b_q        <= 32'd0;
      work_q     <= 64'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_neg_q    <= a_neg_d;
      b_q        <= b_d;
      work_q     <= work_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_mult_unit.sv
module tb_div_mult_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  div_mult_ctrl;
  logic [31:0] A, B, Hi, Lo;
  logic        busy, done, div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_exp = 64'd0;

  always #5 clk = ~clk;

  div_mult_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .div_mult_ctrl(div_mult_ctrl),
    .A            (A),
    .B            (B),
    .Hi           (Hi),
    .Lo           (Lo),
    .busy         (busy),
    .done         (done),
    .div_zero     (div_zero)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // done and div_zero must never coincide.
  always @(negedge clk) begin
    n_checks++;
    if (done === 1'b1 && div_zero === 1'b1) begin
      n_fail++;
      $display("FAIL done_and_div_zero: got 1, expected 0 at %0t", $time);
    end
  end

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic logic [63:0] model(input logic [1:0] ctrl, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (ctrl == 2'b01) return sa * sb;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_op(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input bit spam, input string name, input logic [63:0] exp);
    int lat, busy_cnt;
    bit seen;
    lat = 0; busy_cnt = 0; seen = 0;
    @(negedge clk);
    start = 1'b1; div_mult_ctrl = ctrl; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; div_mult_ctrl = 2'b00;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (spam && (k == 5 || k == 20)) begin
        start = 1'b1; div_mult_ctrl = 2'b01; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    start = 1'b0;
    check({name, " done_seen"}, 64'(seen), 64'd1);
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({name, " result"}, {Hi, Lo}, exp);
    @(posedge clk); #1;
    check({name, " done_width"}, 64'(done), 64'd0);
    check({name, " result_hold"}, {Hi, Lo}, exp);
    last_exp = exp;
  endtask

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];
  int   done_cnt;

  initial begin
    vecs[0] = '{2'b01, 32'd7,         32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB};
    vecs[1] = '{2'b01, 32'h80000000,  32'h80000000, 64'h40000000_00000000};
    vecs[2] = '{2'b10, 32'hFFFFFFF9,  32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[3] = '{2'b10, 32'd7,         32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    vecs[4] = '{2'b10, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[5] = '{2'b10, 32'd100,       32'd7,        64'h00000002_0000000E};
    vecs[6] = '{2'b01, 32'd0,         32'h12345678, 64'h00000000_00000000};

    reset = 1'b0; start = 1'b0; div_mult_ctrl = 2'b00; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi_lo", {Hi, Lo}, 64'd0);
    check("reset flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, (i == 1), $sformatf("vec%0d", i), vecs[i].exp);
    end

    // Divide by zero: flag pulse only, result untouched, next start accepted at once.
    @(negedge clk);
    start = 1'b1; div_mult_ctrl = 2'b10; A = 32'd5; B = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("divz pulse", 64'(div_zero), 64'd1);
    check("divz busy_done", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #1;
    check("divz pulse_end", {61'd0, div_zero, busy, done}, 64'd0);
    check("divz hold", {Hi, Lo}, last_exp);
    do_op(2'b01, 32'd6, 32'd9, 1'b0, "after_divz", 64'd54);

    // ctrl 00 and 11 are no-ops.
    for (int c = 0; c < 4; c += 3) begin
      @(negedge clk);
      start = 1'b1; div_mult_ctrl = 2'(c); A = 32'd1; B = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check($sformatf("nop%0d flags", c), {61'd0, busy, done, div_zero}, 64'd0);
      check($sformatf("nop%0d hold", c), {Hi, Lo}, last_exp);
    end

    // Reset during a MULT aborts it.
    @(negedge clk);
    start = 1'b1; div_mult_ctrl = 2'b01; A = 32'h12345678; B = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrun_reset hi_lo", {Hi, Lo}, 64'd0);
    check("midrun_reset flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midrun_reset no_done", 64'(done_cnt), 64'd0);
    do_op(2'b01, 32'd3, 32'd4, 1'b1, "mult_3x4", 64'd12);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ctrl;
      logic [31:0] ra, rb;
      ctrl = (i % 2 == 0) ? 2'b01 : 2'b10;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 6 == 1) ra = -ra;
      if (i % 5 == 3) rb = -rb;
      if (rb == 32'd0) rb = 32'd1;
      do_op(ctrl, ra, rb, (i % 4 == 0), $sformatf("rand%0d", i), model(ctrl, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
